// File: rtl/acq_pkg.sv
// ----------------------------------------------------------------------------
// acq_pkg
// Shared constants, types and helpers for the strip histogram block.
//   BIN_COUNT   number of bins per axis
//   IDX_W       width of a bin index
//   CNT_W       width of a bin / status counter
//   CNT_SAT     saturation value of every counter
//   acq_state_t acquisition FSM states
//   sat_inc()   saturating +1 on a CNT_W counter
// ----------------------------------------------------------------------------
package acq_pkg;

    localparam int unsigned BIN_COUNT = 128;
    localparam int unsigned IDX_W     = 7;
    localparam int unsigned CNT_W     = 16;

    localparam logic [CNT_W-1:0] CNT_SAT  = '1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BIN_COUNT - 1);

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_ACCUM,
        ST_HOLD
    } acq_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_SAT) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/frame_timer.sv
// ----------------------------------------------------------------------------
// frame_timer
// 32-bit frame length counter. Held at zero while load is high, counts while
// count_en is high, and flags expire during the last counted cycle of a frame.
//   clk       block clock
//   reset     asynchronous active-high reset (count -> 0)
//   load      force count to 0
//   count_en  advance count by one per cycle
//   expire    high in the final cycle of a FRAME_CYCLES-long frame
// ----------------------------------------------------------------------------
module frame_timer #(
    parameter int unsigned FRAME_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic count_en,
    output logic expire
);

    localparam logic [31:0] LAST_COUNT = 32'(FRAME_CYCLES - 1);

    logic [31:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (count_en) begin
            count <= count + 32'd1;
        end
    end

    assign expire = count_en && (count == LAST_COUNT);

endmodule

// File: rtl/strip_histogram.sv
// ----------------------------------------------------------------------------
// strip_histogram
// Accumulates x/y strip hit histograms over fixed-length frames, freezes them
// for read-out, then clears and (if enabled) starts the next frame.
//   clk, reset                 clock, asynchronous active-high reset
//   acquire_enable             permits a new frame to start
//   hit_valid, hit_x, hit_y    one detector hit and its bins
//   start_sending              histogram frozen, read-out permitted (HOLD)
//   read_index_yaxis/_xaxis    bins selected by the read-out stage
//   data_yaxis/_xaxis          combinational bin counts at the read indices
//   acquiring                  high while accumulating
//   frame_count                completed frames, wrapping
//   dropped_hits               hits seen outside accumulation, saturating
// ----------------------------------------------------------------------------
module strip_histogram
    import acq_pkg::*;
#(
    parameter int unsigned FRAME_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             acquire_enable,
    input  logic             hit_valid,
    input  logic [IDX_W-1:0] hit_x,
    input  logic [IDX_W-1:0] hit_y,
    output logic             start_sending,
    input  logic [IDX_W-1:0] read_index_yaxis,
    input  logic [IDX_W-1:0] read_index_xaxis,
    output logic [CNT_W-1:0] data_yaxis,
    output logic [CNT_W-1:0] data_xaxis,
    output logic             acquiring,
    output logic [CNT_W-1:0] frame_count,
    output logic [CNT_W-1:0] dropped_hits
);

    acq_state_t       state;
    logic [IDX_W-1:0] clear_index;
    logic             seen_top;
    logic             frame_done;

    logic [CNT_W-1:0] hist_x [BIN_COUNT];
    logic [CNT_W-1:0] hist_y [BIN_COUNT];

    // Timer sits at zero outside ACCUM, so it starts every frame from 0.
    frame_timer #(
        .FRAME_CYCLES(FRAME_CYCLES)
    ) u_frame_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (state != ST_ACCUM),
        .count_en (state == ST_ACCUM),
        .expire   (frame_done)
    );

    // Histogram storage: no reset, the CLEAR sweep zeroes it. A hit is a
    // read-modify-write in one cycle, so back-to-back hits to a bin all land.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            hist_x[clear_index] <= '0;
            hist_y[clear_index] <= '0;
        end else if (state == ST_ACCUM && hit_valid) begin
            hist_x[hit_x] <= sat_inc(hist_x[hit_x]);
            hist_y[hit_y] <= sat_inc(hist_y[hit_y]);
        end
    end

    assign data_xaxis = hist_x[read_index_xaxis];
    assign data_yaxis = hist_y[read_index_yaxis];

    // Acquisition FSM with registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_CLEAR;
            clear_index   <= '0;
            start_sending <= 1'b0;
            acquiring     <= 1'b0;
            seen_top      <= 1'b0;
            frame_count   <= '0;
            dropped_hits  <= '0;
        end else begin
            if (hit_valid && state != ST_ACCUM) begin
                dropped_hits <= sat_inc(dropped_hits);
            end

            case (state)
                ST_CLEAR: begin
                    clear_index <= clear_index + 1'b1;
                    if (clear_index == IDX_LAST) begin
                        if (acquire_enable) begin
                            state     <= ST_ACCUM;
                            acquiring <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end

                ST_IDLE: begin
                    if (acquire_enable) begin
                        state     <= ST_ACCUM;
                        acquiring <= 1'b1;
                    end
                end

                ST_ACCUM: begin
                    if (frame_done) begin
                        state         <= ST_HOLD;
                        acquiring     <= 1'b0;
                        start_sending <= 1'b1;
                        frame_count   <= frame_count + 1'b1;
                    end
                end

                ST_HOLD: begin
                    // Leave only after the read-out has swept 127 back to 0.
                    if (seen_top && read_index_yaxis == '0) begin
                        state         <= ST_CLEAR;
                        start_sending <= 1'b0;
                        seen_top      <= 1'b0;
                        clear_index   <= '0;
                    end else if (read_index_yaxis == IDX_LAST) begin
                        seen_top <= 1'b1;
                    end
                end

                default: begin
                    state <= ST_CLEAR;
                end
            endcase
        end
    end

endmodule
